dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 106 ++++++++++
 tb/tb_dmem_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- single-port data memory shared by the datapath (core) and a
// host port. The core has priority. The host is granted only in IDLE, either
// when the core is quiet or, after STARVE_LIMIT cycles of losing to the core,
// by force. A forced grant drops the core access for that cycle and raises
// core_stall so the datapath retries.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   core_addr/wdata       datapath word address / store data
//   core_wena, core_ren   store / load strobes (store wins if both are set)
//   core_rdata, rvalid    registered load data, valid one cycle after load
//   core_stall            core access dropped this cycle (forced host grant)
//   host_req/we/addr/wdata host request, held until host_ack
//   host_ack, host_rdata  one-cycle completion pulse, read data with ack
module dmem_ctrl #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic                  core_wena,
  input  logic                  core_ren,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_rvalid,
  output logic                  core_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                state;
  logic [CW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic core_acc;
  logic host_grant;
  logic core_wr_go;
  logic core_rd_go;

  // A forced grant only needs IDLE, a pending request and a saturated counter;
  // the core access (if any) is what gets dropped.
  always_comb begin
    core_acc   = core_wena | core_ren;
    core_stall = (state == IDLE) && host_req && (wait_cnt == LIMIT);
    host_grant = !rst && (state == IDLE) && host_req && (!core_acc || core_stall);
    core_wr_go = !rst && core_wena && !core_stall;
    core_rd_go = !rst && core_ren && !core_wena && !core_stall;
  end

  // Array is intentionally not reset. Core and host grants are mutually
  // exclusive, so only one port touches the array per cycle.
  always_ff @(posedge clk) begin
    if (core_wr_go) begin
      mem[core_addr] <= core_wdata;
    end else if (host_grant && host_we) begin
      mem[host_addr] <= host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
    end else begin
      core_rvalid <= core_rd_go;
      if (core_rd_go) begin
        core_rdata <= mem[core_addr];
      end

      // Host read data is captured at grant and presented with the ack.
      if (host_grant && !host_we) begin
        host_rdata <= mem[host_addr];
      end
      host_ack <= host_grant;

      case (state)
        IDLE:    state <= host_grant ? ACK : IDLE;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!host_req || host_grant) begin
        wait_cnt <= '0;
      end else if ((state == IDLE) && core_acc && (wait_cnt != LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with default parameters. Inputs change 1 ns
// after each rising edge; outputs are sampled at the same point.
module tb_dmem_ctrl;

  localparam int DW = 64;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_wena;
  logic          core_ren;
  logic [DW-1:0] core_rdata;
  logic          core_rvalid;
  logic          core_stall;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wena  (core_wena),
    .core_ren   (core_ren),
    .core_rdata (core_rdata),
    .core_rvalid(core_rvalid),
    .core_stall (core_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; core_addr = '0; core_wdata = '0; core_wena = 1'b0; core_ren = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rvalid", 64'(core_rvalid), 64'd0);
    chk("rst_rdata",  core_rdata,       64'd0);
    chk("rst_ack",    64'(host_ack),    64'd0);
    chk("rst_hrdata", host_rdata,       64'd0);
    chk("rst_stall",  64'(core_stall),  64'd0);

    // Core write then read of 0x10.
    core_wena = 1'b1; core_addr = 8'h10; core_wdata = 64'h0004_0003_0002_0001;
    tick();
    chk("wr_rvalid", 64'(core_rvalid), 64'd0);
    core_wena = 1'b0; core_ren = 1'b1;
    tick();
    chk("rd10_rvalid", 64'(core_rvalid), 64'd1);
    chk("rd10_rdata",  core_rdata,       64'h0004_0003_0002_0001);
    core_ren = 1'b0;
    tick();
    chk("idle_rvalid", 64'(core_rvalid), 64'd0);
    chk("idle_hold",   core_rdata,       64'h0004_0003_0002_0001);

    // Host write 0x20 with core idle, then host read back.
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 64'hDEAD_BEEF;
    chk("hwr_nostall", 64'(core_stall), 64'd0);
    tick();
    chk("hwr_ack",    64'(host_ack), 64'd1);
    chk("hwr_hrdata", host_rdata,    64'd0);
    host_req = 1'b0;
    tick();
    chk("hwr_ack_end", 64'(host_ack), 64'd0);
    host_req = 1'b1; host_we = 1'b0;
    tick();
    chk("hrd_ack",    64'(host_ack), 64'd1);
    chk("hrd_hrdata", host_rdata,    64'hDEAD_BEEF);
    // Request still held through ACK: must not produce a second grant.
    tick();
    chk("hrd_no_double", 64'(host_ack), 64'd0);
    chk("hrd_hold",      host_rdata,    64'hDEAD_BEEF);
    host_req = 1'b0;

    // Starvation: core reads every cycle while host write to 0x21 waits.
    core_ren = 1'b1; core_addr = 8'h10;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h21; host_wdata = 64'h1234;
    chk("starve_w0_stall", 64'(core_stall), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("starve_w%0d_rvalid", i + 1), 64'(core_rvalid), 64'd1);
      chk($sformatf("starve_w%0d_stall", i + 1), 64'(core_stall), (i == 3) ? 64'd1 : 64'd0);
      chk($sformatf("starve_w%0d_ack", i + 1), 64'(host_ack), 64'd0);
    end
    tick();
    chk("forced_ack",     64'(host_ack),    64'd1);
    chk("forced_dropped", 64'(core_rvalid), 64'd0);
    chk("forced_nostall", 64'(core_stall),  64'd0);
    host_req = 1'b0; core_addr = 8'h21;
    tick();
    chk("ack_core_rvalid", 64'(core_rvalid), 64'd1);
    chk("ack_core_rdata",  core_rdata,       64'h1234);
    chk("ack_done",        64'(host_ack),    64'd0);
    core_ren = 1'b0;

    // Simultaneous store and load to 0x05: store only.
    core_wena = 1'b1; core_ren = 1'b1; core_addr = 8'h05; core_wdata = 64'h55;
    tick();
    chk("both_rvalid", 64'(core_rvalid), 64'd0);
    core_wena = 1'b0;
    tick();
    chk("rd05_rvalid", 64'(core_rvalid), 64'd1);
    chk("rd05_rdata",  core_rdata,       64'h55);
    core_ren = 1'b0;

    // Preload 0x30, host read, reset during ACK with a store presented.
    core_wena = 1'b1; core_addr = 8'h30; core_wdata = 64'hA5A5;
    tick();
    core_wena = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    tick();
    chk("pre_rst_ack",    64'(host_ack), 64'd1);
    chk("pre_rst_hrdata", host_rdata,    64'hA5A5);
    rst = 1'b1; core_wena = 1'b1; core_wdata = 64'hFFFF;
    tick();
    chk("rst_ack_ack",    64'(host_ack),    64'd0);
    chk("rst_ack_hrdata", host_rdata,       64'd0);
    chk("rst_ack_rvalid", 64'(core_rvalid), 64'd0);
    chk("rst_ack_rdata",  core_rdata,       64'd0);
    chk("rst_ack_stall",  64'(core_stall),  64'd0);
    rst = 1'b0; host_req = 1'b0; core_wena = 1'b0; core_ren = 1'b1;
    tick();
    chk("rst_ack_noack",  64'(host_ack),    64'd0);
    chk("retain_rvalid",  64'(core_rvalid), 64'd1);
    chk("retain_rdata",   core_rdata,       64'hA5A5);
    core_ren = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
